// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter sharing one regfile write port between the in-order WB port (0)
// and a long-latency port (1), with WAW discard of stale port-1 writes and a starvation guard.
module regfile_wb_arbiter #(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            p0_valid,
    output logic            p0_ready,
    input  logic [4:0]      p0_dest,
    input  logic [XLEN-1:0] p0_data,
    input  logic            p1_valid,
    output logic            p1_ready,
    input  logic [4:0]      p1_dest,
    input  logic [XLEN-1:0] p1_data,
    output logic            rf_load,
    output logic            rf_use_rd,
    output logic [4:0]      rf_dest,
    output logic [XLEN-1:0] rf_data,
    output logic            p1_starved,
    output logic [15:0]     drop_cnt
);

    localparam int unsigned DEST_W = 5;
    localparam int unsigned WAIT_W = $clog2(STARVE_LIMIT + 1);
    localparam int unsigned CNT_W  = 16;

    typedef enum logic {
        NORMAL = 1'b0,
        FORCE1 = 1'b1
    } mode_t;

    mode_t               mode;
    mode_t               mode_nxt;
    logic [WAIT_W-1:0]   wait_cnt;
    logic [WAIT_W-1:0]   wait_nxt;
    logic [CNT_W-1:0]    drop_nxt;
    logic                grant0_c;
    logic                grant1_c;
    logic                waw_drop_c;
    logic [DEST_W-1:0]   win_dest_c;
    logic [XLEN-1:0]     win_data_c;

    // Mode, wait counter and drop counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode     <= NORMAL;
            wait_cnt <= '0;
            drop_cnt <= '0;
        end else begin
            mode     <= mode_nxt;
            wait_cnt <= wait_nxt;
            drop_cnt <= drop_nxt;
        end
    end

    // Grant selection, ready generation and next-state logic
    always_comb begin
        mode_nxt   = mode;
        wait_nxt   = wait_cnt;
        drop_nxt   = drop_cnt;
        grant0_c   = 1'b0;
        grant1_c   = 1'b0;
        waw_drop_c = 1'b0;
        p0_ready   = 1'b0;
        p1_ready   = 1'b0;

        if (mode == FORCE1) begin
            grant1_c = p1_valid;
            grant0_c = p0_valid && !p1_valid;
        end else begin
            grant0_c = p0_valid;
            grant1_c = p1_valid && !p0_valid;
        end

        // Port 0 is younger: a same-dest port-1 write is stale and is retired unwritten
        waw_drop_c = grant0_c && p1_valid && (p0_dest == p1_dest);
        p0_ready   = grant0_c;
        p1_ready   = grant1_c || waw_drop_c;

        if (p1_ready) begin
            wait_nxt = '0;
        end else if (p1_valid && (wait_cnt < WAIT_W'(STARVE_LIMIT))) begin
            wait_nxt = wait_cnt + WAIT_W'(1);
        end

        if (waw_drop_c && (drop_cnt != '1)) begin
            drop_nxt = drop_cnt + CNT_W'(1);
        end

        case (mode)
            NORMAL:  if (wait_nxt == WAIT_W'(STARVE_LIMIT)) mode_nxt = FORCE1;
            FORCE1:  if (grant1_c) mode_nxt = NORMAL;
            default: mode_nxt = NORMAL;
        endcase
    end

    assign win_dest_c = grant1_c ? p1_dest : p0_dest;
    assign win_data_c = grant1_c ? p1_data : p0_data;

    // Registered write stage; x0 targets consume the grant but never reach the regfile
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_load <= 1'b0;
            rf_dest <= '0;
            rf_data <= '0;
        end else begin
            rf_load <= (grant0_c || grant1_c) && (win_dest_c != '0);
            if ((grant0_c || grant1_c) && (win_dest_c != '0)) begin
                rf_dest <= win_dest_c;
                rf_data <= win_data_c;
            end
        end
    end

    assign rf_use_rd  = rf_load;
    assign p1_starved = (mode == FORCE1);

endmodule
